scaler_ctrl: RTL and testbench
==============================

SCALER_CTRL -- requirements
Module: scaler_ctrl

Interface
REQ-001 Parameter CLR_WORDS, default 76800: framebuffer words cleared before each job (320x240).
REQ-002 Parameter TIMEOUT, default 262143: max RUN cycles before fault.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 seletor  input  2  algorithm: 00 replication, 01 decimation, 10 nearest neighbour, 11 average.
REQ-006 start  input  1  job request, sampled each cycle.
REQ-007 eng_start  output  4  one-hot start pulse; bit k = engine k (k = seletor code).
REQ-008 eng_done  input  4  per-engine done level.
REQ-009 eng_rom_addr  input  76  4x19 packed; engine k at bits [19k+18:19k].
REQ-010 eng_ram_addr  input  76  4x19 packed, same packing.
REQ-011 eng_ram_data  input  32  4x8 packed; engine k at bits [8k+7:8k].
REQ-012 eng_wren  input  4  per-engine RAM write enable.
REQ-013 rom_addr  output  19  ROM read address.
REQ-014 ram_wraddr  output  19  framebuffer write address.
REQ-015 ram_data  output  8  framebuffer write data.
REQ-016 ram_wren  output  1  framebuffer write enable.
REQ-017 mode  output  2  latched algorithm of current/last job.
REQ-018 busy  output  1  high in CLEAR, LAUNCH, RUN.
REQ-019 done  output  1  high in FINISH only.
REQ-020 fault  output  1  high in FAULT only.

Function
REQ-021 States SHALL be IDLE, CLEAR, LAUNCH, RUN, FINISH, FAULT.
REQ-022 Job trigger SHALL be start=1, or seletor differing from mode, while in IDLE, FINISH or FAULT.
REQ-023 On trigger: mode<=seletor, clear counter<=0, go CLEAR.
REQ-024 CLEAR: ram_wren=1, ram_data=0, rom_addr=0, ram_wraddr=counter; counter+1 per cycle; after address CLR_WORDS-1 go LAUNCH.
REQ-025 LAUNCH lasts exactly one cycle: eng_start[mode]=1, other bits 0; timeout counter<=0; go RUN.
REQ-026 eng_start SHALL be 0 in every other state.
REQ-027 RUN: rom_addr, ram_wraddr, ram_data, ram_wren SHALL be registered copies of engine[mode] signals, one cycle latency.
REQ-028 RUN: eng_done[mode]=1 -> FINISH next cycle; non-selected eng_done/eng_wren ignored.
REQ-029 RUN: timeout counter reaching TIMEOUT without done -> FAULT.
REQ-030 Outside CLEAR and RUN, ram_wren SHALL be 0; address/data hold last value.
REQ-031 seletor change during CLEAR/LAUNCH/RUN SHALL set pending; current job completes unaltered.
REQ-032 pending set on entering FINISH or FAULT: next cycle re-trigger with current seletor, pending cleared.
REQ-033 start during CLEAR/LAUNCH/RUN SHALL be ignored (no pending).
REQ-034 Trigger and eng_done in same cycle in RUN: done wins; trigger handled per REQ-031.
REQ-035 Clear counter 17 bits, timeout counter 18 bits; neither wraps.

Reset
REQ-036 reset=1 SHALL immediately force IDLE, mode=00, pending=0, counters=0, all outputs 0.
REQ-037 reset mid-CLEAR or mid-RUN SHALL abort without further ram_wren; no auto-restart unless seletor!=00 after release (REQ-022).
REQ-038 First trigger after reset requires start=1 or seletor!=00.

Verification
REQ-039 Reset, seletor=00, start pulse -> 76800 zero writes addr 0..76799, then eng_start=0001 for one cycle, busy=1 throughout.
REQ-040 RUN mode 01, engine drives addr 0x00123/data 0xA5/wren 1 -> ram_wraddr=0x00123, ram_data=0xA5, ram_wren=1 one cycle later.
REQ-041 RUN, eng_done=0001 while mode=01 -> ignored; eng_done=0010 -> done=1, busy=0 next cycle.
REQ-042 seletor 00->10 mid-RUN -> job finishes in mode 00, done one cycle, then CLEAR, eng_start=0100.
REQ-043 RUN, no eng_done for TIMEOUT cycles -> fault=1, ram_wren=0; start pulse -> new CLEAR.
REQ-044 reset at CLEAR address 1000 -> all outputs 0 same cycle, IDLE, no writes after release with seletor=00, start=0.

Source files
------------

// File: rtl/scaler_ctrl.sv
// Framebuffer scaler controller: clears the framebuffer, launches the selected
// scaling engine and forwards its RAM/ROM traffic until done or timeout.
module scaler_ctrl #(
    parameter int CLR_WORDS = 76800,
    parameter int TIMEOUT   = 262143
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  seletor,
    input  logic        start,
    output logic [3:0]  eng_start,
    input  logic [3:0]  eng_done,
    input  logic [75:0] eng_rom_addr,
    input  logic [75:0] eng_ram_addr,
    input  logic [31:0] eng_ram_data,
    input  logic [3:0]  eng_wren,
    output logic [18:0] rom_addr,
    output logic [18:0] ram_wraddr,
    output logic [7:0]  ram_data,
    output logic        ram_wren,
    output logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_RUN,
        S_FINISH,
        S_FAULT
    } state_t;

    localparam logic [16:0] CLR_LAST = 17'(CLR_WORDS - 1);
    localparam logic [17:0] TMO_LAST = 18'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [16:0] clr_cnt;
    logic [17:0] tmo_cnt;
    logic        pending;
    logic        trigger;

    logic [18:0] sel_rom, sel_ram;
    logic [7:0]  sel_data;
    logic        sel_wren, sel_done;

    logic [18:0] rom_addr_p1, wraddr_p1;
    logic [7:0]  data_p1;
    logic        wren_p1;

    always_comb begin
        sel_rom  = '0;
        sel_ram  = '0;
        sel_data = '0;
        sel_wren = 1'b0;
        sel_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (mode == 2'(k)) begin
                sel_rom  = eng_rom_addr[19*k +: 19];
                sel_ram  = eng_ram_addr[19*k +: 19];
                sel_data = eng_ram_data[8*k +: 8];
                sel_wren = eng_wren[k];
                sel_done = eng_done[k];
            end
        end
    end

    assign trigger = start || (seletor != mode) || pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FINISH, S_FAULT: begin
                if (trigger) state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_cnt == CLR_LAST) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN: begin
                // completion takes priority over the timeout in the same cycle
                if (sel_done) begin
                    state_nxt = S_FINISH;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_FAULT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode    <= 2'b00;
            pending <= 1'b0;
            clr_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                S_IDLE, S_FINISH, S_FAULT: begin
                    if (trigger) begin
                        mode    <= seletor;
                        clr_cnt <= '0;
                        pending <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (seletor != mode) pending <= 1'b1;
                    if (clr_cnt != CLR_LAST) clr_cnt <= clr_cnt + 17'd1;
                end
                S_LAUNCH: begin
                    if (seletor != mode) pending <= 1'b1;
                    tmo_cnt <= '0;
                end
                S_RUN: begin
                    if (seletor != mode) pending <= 1'b1;
                    if (!sel_done) tmo_cnt <= tmo_cnt + 18'd1;
                end
                default: ;
            endcase
        end
    end

    // ---- stage p1: registered framebuffer/ROM port ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_addr_p1 <= '0;
            wraddr_p1   <= '0;
            data_p1     <= '0;
            wren_p1     <= 1'b0;
        end else begin
            wren_p1 <= 1'b0;
            if (state == S_CLEAR) begin
                rom_addr_p1 <= '0;
                wraddr_p1   <= {2'b00, clr_cnt};
                data_p1     <= '0;
            end else if (state == S_RUN) begin
                rom_addr_p1 <= sel_rom;
                wraddr_p1   <= sel_ram;
                data_p1     <= sel_data;
                wren_p1     <= sel_wren;
            end
        end
    end

    always_comb begin
        rom_addr   = rom_addr_p1;
        ram_wraddr = wraddr_p1;
        ram_data   = data_p1;
        ram_wren   = 1'b0;
        eng_start  = 4'b0000;
        if (state == S_CLEAR) begin
            rom_addr   = '0;
            ram_wraddr = {2'b00, clr_cnt};
            ram_data   = '0;
            ram_wren   = 1'b1;
        end else if (state == S_RUN) begin
            ram_wren = wren_p1;
        end else if (state == S_LAUNCH) begin
            eng_start = 4'b0001 << mode;
        end
    end

    assign busy  = (state == S_CLEAR) || (state == S_LAUNCH) || (state == S_RUN);
    assign done  = (state == S_FINISH);
    assign fault = (state == S_FAULT);

endmodule

// File: tb/tb_scaler_ctrl.sv
// Bench for scaler_ctrl: directed job scenarios plus random traffic, all
// outputs compared every cycle against a job-timeline reference model.
module tb_scaler_ctrl;

    localparam int CW = 40;
    localparam int TO = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  seletor;
    logic        start;
    logic [3:0]  eng_start, eng_done, eng_wren;
    logic [75:0] eng_rom_addr, eng_ram_addr;
    logic [31:0] eng_ram_data;
    logic [18:0] rom_addr, ram_wraddr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic [1:0]  mode;
    logic        busy, done, fault;

    int checks = 0;
    int passed = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: a job is a timeline of age 0..CW-1 clearing,
    // age CW launching, age > CW running the engine
    bit          m_active;
    int          m_age;
    int          m_result;   // 0 none, 1 finished, 2 faulted
    logic [1:0]  m_mode;
    bit          m_pend;
    logic [18:0] h_rom, h_addr;
    logic [7:0]  h_data;
    logic        h_wren;

    scaler_ctrl #(.CLR_WORDS(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .seletor(seletor), .start(start),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_rom_addr(eng_rom_addr), .eng_ram_addr(eng_ram_addr),
        .eng_ram_data(eng_ram_data), .eng_wren(eng_wren),
        .rom_addr(rom_addr), .ram_wraddr(ram_wraddr), .ram_data(ram_data),
        .ram_wren(ram_wren), .mode(mode), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(logic b, logic d, logic f, logic [3:0] es,
                                         logic w, logic [18:0] wa, logic [7:0] dt,
                                         logic [18:0] ra, logic [1:0] md);
        return {8'h00, b, d, f, es, w, wa, dt, ra, md};
    endfunction

    task automatic model_reset();
        m_active = 0; m_age = 0; m_result = 0; m_mode = 2'b00; m_pend = 0;
        h_rom = '0; h_addr = '0; h_data = '0; h_wren = 1'b0;
    endtask

    task automatic model_step();
        int idx;
        if (!m_active) begin
            if (start || seletor != m_mode || m_pend) begin
                m_mode = seletor; m_pend = 0; m_active = 1; m_age = 0;
            end
            h_wren = 1'b0;
        end else begin
            if (seletor != m_mode) m_pend = 1;
            if (m_age < CW) begin
                h_addr = 19'(m_age); h_rom = '0; h_data = '0; h_wren = 1'b0;
            end else if (m_age == CW) begin
                h_wren = 1'b0;
            end else begin
                idx = int'(m_mode);
                h_rom  = eng_rom_addr[19*idx +: 19];
                h_addr = eng_ram_addr[19*idx +: 19];
                h_data = eng_ram_data[8*idx +: 8];
                h_wren = eng_wren[idx];
                if (eng_done[idx]) begin
                    m_active = 0; m_result = 1;
                end else if (m_age - CW - 1 == TO - 1) begin
                    m_active = 0; m_result = 2;
                end
            end
            m_age++;
        end
    endtask

    function automatic logic [63:0] model_out();
        bit clr, lch, run;
        clr = m_active && (m_age < CW);
        lch = m_active && (m_age == CW);
        run = m_active && (m_age > CW);
        return pack(m_active, !m_active && m_result == 1, !m_active && m_result == 2,
                    lch ? (4'b0001 << m_mode) : 4'b0000,
                    clr ? 1'b1 : (run ? h_wren : 1'b0),
                    clr ? 19'(m_age) : h_addr, clr ? 8'h00 : h_data,
                    clr ? 19'h0 : h_rom, m_mode);
    endfunction

    task automatic drive_engine();
        logic [3:0] oh;
        oh = 4'b0001 << m_mode;
        eng_rom_addr = 76'({$urandom, $urandom, $urandom});
        eng_ram_addr = 76'({$urandom, $urandom, $urandom});
        eng_ram_data = $urandom;
        eng_wren     = 4'($urandom);
        eng_done     = 4'($urandom) & ~oh;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check("outs", pack(busy, done, fault, eng_start, ram_wren, ram_wraddr,
                           ram_data, rom_addr, mode), model_out());
        @(negedge clk);
        drive_engine();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_outs", pack(busy, done, fault, eng_start, ram_wren, ram_wraddr,
                                 ram_data, rom_addr, mode), 64'h0);
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d observed=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; seletor = 2'b00; start = 1'b0;
        model_reset();
        drive_engine();
        repeat (2) @(negedge clk);
        check("por_outs", pack(busy, done, fault, eng_start, ram_wren, ram_wraddr,
                               ram_data, rom_addr, mode), 64'h0);
        reset = 1'b0;

        // idle: no trigger with seletor=00, start=0
        repeat (3) tick();
        check("idle_busy", 64'(busy), 64'd0);

        // full clear then launch of engine 0
        start = 1'b1; tick(); start = 1'b0;
        check("clr_addr0", 64'(ram_wraddr), 64'd0);
        check("clr_wren", 64'(ram_wren), 64'd1);
        repeat (CW - 1) tick();
        check("clr_last", 64'(ram_wraddr), 64'(CW - 1));
        check("clr_busy", 64'(busy), 64'd1);
        tick();
        check("launch0", 64'(eng_start), 64'h1);
        tick();
        check("run_nostart", 64'(eng_start), 64'h0);
        repeat (5) tick();
        eng_done[0] = 1'b1; tick();
        check("finish0_done", 64'(done), 64'd1);

        // mode 01 forwarding and done selection
        seletor = 2'b01; tick();
        check("mode1", 64'(mode), 64'd1);
        repeat (CW) tick();
        check("launch1", 64'(eng_start), 64'h2);
        tick();
        eng_ram_addr[38:19] = 19'h00123;
        eng_ram_data[15:8]  = 8'hA5;
        eng_wren            = 4'b0010;
        tick();
        check("fwd_addr", 64'(ram_wraddr), 64'h123);
        check("fwd_data", 64'(ram_data), 64'hA5);
        check("fwd_wren", 64'(ram_wren), 64'd1);
        eng_done = 4'b0001; tick();
        check("done_ignored", 64'({busy, done}), 64'b10);
        eng_done = 4'b0010; tick();
        check("done_taken", 64'({busy, done}), 64'b01);

        // seletor change mid-run: job completes in old mode, then re-launch
        seletor = 2'b00; tick();
        repeat (CW + 1) tick();
        seletor = 2'b10; tick();
        repeat (3) tick();
        eng_done[0] = 1'b1; tick();
        check("chg_finish_mode", 64'({done, mode}), 64'b100);
        tick();
        check("chg_reclear", 64'({busy, mode}), 64'b110);
        repeat (CW) tick();
        check("launch2", 64'(eng_start), 64'h4);

        // timeout to fault, then restart
        tick();
        repeat (TO - 1) tick();
        check("pre_timeout_busy", 64'(busy), 64'd1);
        tick();
        check("fault", 64'({fault, ram_wren}), 64'b10);
        start = 1'b1; tick(); start = 1'b0;
        check("fault_restart", 64'({busy, ram_wren, ram_wraddr}), {42'd0, 1'b1, 1'b1, 19'd0} & 64'h1FFFFF);

        // reset in the middle of a clear
        repeat (10) tick();
        seletor = 2'b00;
        do_reset();
        repeat (CW + 5) tick();
        check("post_reset_idle", 64'({busy, ram_wren}), 64'd0);

        // done and seletor change in the same run cycle
        seletor = 2'b01; tick();
        repeat (CW + 1) tick();
        seletor = 2'b11; eng_done[1] = 1'b1; tick();
        check("tie_done", 64'({done, mode}), 64'b101);
        tick();
        check("tie_retrigger", 64'({busy, mode}), 64'b111);

        // pending survives seletor returning to the current mode
        repeat (CW + 1) tick();
        seletor = 2'b00; tick();
        seletor = 2'b11; tick();
        eng_done[3] = 1'b1; tick();
        check("pend_finish", 64'(done), 64'd1);
        tick();
        check("pend_retrigger", 64'({busy, mode}), 64'b111);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(9) == 0);
            if ($urandom_range(24) == 0) seletor = 2'($urandom);
            if (m_active && m_age > CW && $urandom_range(14) == 0) eng_done[m_mode] = 1'b1;
            if (i == 700) do_reset();
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
